ring_fsm_n: RTL

- Parametrised N-state ring sequencer, successor to the fixed 4-state ring FSM.
- IN steps the state up (IN=1) or down (IN=0) modulo N_STATES.
- A registered MATCH flags when the previous-cycle state equals a runtime-selectable target.
- Adds step enable, synchronous load, wrap pulse, live state output and optional saturating hit counter; sits in the same control/sequence-detect layer as the 4-state block.

---
 rtl/ring_fsm_pkg.sv | 32 +++
 rtl/ring_hit_counter.sv | 28 ++
 rtl/ring_fsm_n.sv | 93 +++++++++
 3 files changed

// File: rtl/ring_fsm_pkg.sv
// Shared types and the ring step function for the N-state ring sequencer.
// Imported by ring_fsm_n and ring_hit_counter.

package ring_fsm_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   localparam int RING_STATE_RESET = 0;

   typedef struct packed {
      logic [31:0] state;
      logic        wrap;
   } ring_step_t;

   // A wrap is any move between the two ends of the ring; with N=2 every step is one.
   function automatic ring_step_t ring_next(input int unsigned state,
                                            input dir_e        dir,
                                            input int unsigned n);
      ring_step_t r;
      if (dir == DIR_UP)
         r.state = (state == n - 1) ? 32'd0 : state + 1;
      else
         r.state = (state == 0) ? n - 1 : state - 1;
      r.wrap = ((state == n - 1) && (r.state == 32'd0)) ||
               ((state == 0) && (r.state == n - 1));
      return r;
   endfunction

endpackage

// File: rtl/ring_hit_counter.sv
// Saturating match counter for ring_fsm_n; only built when RING_FSM_HITCNT_EN is defined,
// so the default build carries no counter at all.

`ifdef RING_FSM_HITCNT_EN
module ring_hit_counter
   import ring_fsm_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             INC,
   output logic [CNT_W-1:0] COUNT
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge CLK) begin
      if (RST)
         count_q <= '0;
      else if (INC && (count_q != {CNT_W{1'b1}}))
         count_q <= count_q + 1'b1;
   end

   assign COUNT = count_q;

endmodule
`endif

// File: rtl/ring_fsm_n.sv
// Parametrised N-state up/down ring sequencer with load, registered match and wrap pulse.
// Define RING_FSM_HITCNT_EN to add the saturating HITS counter (width CNT_W).

module ring_fsm_n
   import ring_fsm_pkg::*;
#(
   parameter int N_STATES = 4,
`ifdef RING_FSM_HITCNT_EN
   parameter int CNT_W    = 8,
`endif
   localparam int SW      = $clog2(N_STATES)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          EN,
   input  logic          IN,
   input  logic          LOAD,
   input  logic [SW-1:0] LOAD_VAL,
   input  logic [SW-1:0] MATCH_SEL,
   output logic [SW-1:0] STATE,
   output logic          MATCH,
   output logic          WRAP
`ifdef RING_FSM_HITCNT_EN
   ,
   output logic [CNT_W-1:0] HITS
`endif
);

   if ((N_STATES < 2) || (N_STATES > 256)) begin : g_bad_n
      $error("ring_fsm_n: N_STATES must be within 2..256");
   end

   // One extra bit so N_STATES = 2^SW is representable for range checks.
   localparam logic [SW:0] N_LIMIT = (SW + 1)'(N_STATES);

   logic [SW-1:0] state_q, state_d;
   logic          match_q, match_d;
   logic          wrap_q,  wrap_d;
   logic          state_ok, load_ok, sel_ok;
   ring_step_t    step;

   assign state_ok = {1'b0, state_q}   < N_LIMIT;
   assign load_ok  = {1'b0, LOAD_VAL}  < N_LIMIT;
   assign sel_ok   = {1'b0, MATCH_SEL} < N_LIMIT;

   // An out-of-range target must not match a corrupted state holding the same code.
   assign match_d  = (state_q == MATCH_SEL) && sel_ok;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d = state_q;
      wrap_d  = 1'b0;
      step    = ring_next(32'(state_q), dir_e'(IN), N_STATES);

      if (LOAD)
         state_d = load_ok ? LOAD_VAL : SW'(RING_STATE_RESET);
      else if (!state_ok)
         state_d = SW'(RING_STATE_RESET);
      else if (EN) begin
         state_d = SW'(step.state);
         wrap_d  = step.wrap;
      end
   end

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RST) begin
         state_q <= SW'(RING_STATE_RESET);
         match_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         match_q <= match_d;
         wrap_q  <= wrap_d;
      end
   end

   assign STATE = state_q;
   assign MATCH = match_q;
   assign WRAP  = wrap_q;

`ifdef RING_FSM_HITCNT_EN
   ring_hit_counter #(
      .CNT_W (CNT_W)
   ) u_hit_counter (
      .CLK   (CLK),
      .RST   (RST),
      .INC   (match_d),
      .COUNT (HITS)
   );
`endif

endmodule
